lcd_refresh_sched: RTL and testbench



---
 rtl/lcd_sched_pkg.sv | 45 ++++
 rtl/lcd_refresh_sched_delay_timer.sv | 30 +++
 rtl/lcd_refresh_sched.sv | 244 ++++++++++++++++++++++++
 tb/tb_lcd_refresh_sched.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_sched_pkg.sv
// Shared definitions for the LCD refresh scheduler.
// Holds the sequencer state encoding, the fixed display init command list,
// the DDRAM line stride and the RS encodings used on the writer interface.
package lcd_sched_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT = 3'd0,
        INIT     = 3'd1,
        CLR_WAIT = 3'd2,
        ADDR     = 3'd3,
        CHAR     = 3'd4,
        SHOWN    = 3'd5,
        SETTLE   = 3'd6
    } state_t;

    localparam int         INIT_CNT      = 4;
    localparam logic [1:0] INIT_CLR_IDX  = 2'd2;
    localparam logic [1:0] INIT_LAST_IDX = 2'(INIT_CNT - 1);

    localparam logic [7:0] CMD_FUNC_SET  = 8'h38;
    localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_ENTRY     = 8'h06;
    localparam logic [7:0] CMD_SET_DDRAM = 8'h80;

    localparam logic [7:0] LINE_STRIDE   = 8'h40;

    localparam logic RS_CMD  = 1'b0;
    localparam logic RS_CHAR = 1'b1;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return CMD_FUNC_SET;
            2'd1:    return CMD_DISP_ON;
            2'd2:    return CMD_CLEAR;
            default: return CMD_ENTRY;
        endcase
    endfunction

    // States in which a byte is being offered to the writer.
    function automatic logic is_send_state(input state_t s);
        return (s == INIT) || (s == ADDR) || (s == CHAR);
    endfunction

endpackage

// File: rtl/lcd_refresh_sched_delay_timer.sv
// Up-counter used for every fixed wait of the scheduler.
// Ports: clk/rst_n clock and async active-low reset; clr restarts the count
// at zero; en advances it; term is the terminal value; done is high while
// the count equals term. The count parks at term instead of wrapping.
module delay_timer #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic         done
);

    logic [W-1:0] cnt;

    assign done = (cnt == term);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !done) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/lcd_refresh_sched.sv
// Character display refresh scheduler.
// Waits for display power-up, sends the init command list, then writes the
// whole text bus once. Afterwards it rewrites the display when the text has
// changed and stayed stable for SETTLE_CYC cycles, or on iREFRESH.
// Ports: iCLK/iRST_N clock and async active-low reset; iDATA flat text bus
// (char 0 in the top byte); iREFRESH forces a pass; oLCD_REQ/oLCD_RS/
// oLCD_DATA/iLCD_ACK one-byte handshake to the writer; oBUSY high while a
// sequence runs; oSHOWN high while the display holds the shadow text.
module lcd_refresh_sched
    import lcd_sched_pkg::*;
#(
    parameter int N_LINES    = 2,
    parameter int LINE_LEN   = 45,
    parameter int PWR_CYC    = 20'hFFFFF,
    parameter int CLR_CYC    = 100000,
    parameter int SETTLE_CYC = 50000
) (
    input  logic                          iCLK,
    input  logic                          iRST_N,
    input  logic [N_LINES*LINE_LEN*8-1:0] iDATA,
    input  logic                          iREFRESH,
    output logic                          oLCD_REQ,
    output logic                          oLCD_RS,
    output logic [7:0]                    oLCD_DATA,
    input  logic                          iLCD_ACK,
    output logic                          oBUSY,
    output logic                          oSHOWN
);

    localparam int N       = N_LINES * LINE_LEN;
    localparam int MAX_A   = (PWR_CYC > CLR_CYC) ? PWR_CYC : CLR_CYC;
    localparam int MAX_CYC = (MAX_A > SETTLE_CYC) ? MAX_A : SETTLE_CYC;
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int CW      = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
    localparam int LW      = $clog2(N_LINES) + 1;

    localparam logic [TW-1:0] PWR_TERM    = TW'(PWR_CYC - 1);
    localparam logic [TW-1:0] CLR_TERM    = TW'(CLR_CYC - 1);
    localparam logic [TW-1:0] SETTLE_TERM = TW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] LAST_COL    = CW'(LINE_LEN - 1);
    localparam logic [LW-1:0] LAST_LINE   = LW'(N_LINES - 1);

    state_t           state, state_nx;
    logic [1:0]       init_idx, init_idx_nx;
    logic [LW-1:0]    line, line_nx;
    logic [CW-1:0]    col, col_nx;
    logic [N*8-1:0]   shadow, shadow_nx;
    logic [N*8-1:0]   cmp, cmp_nx;
    logic             pending, pending_nx;
    logic             req, req_nx;
    logic             rs;
    logic [7:0]       data;
    logic             send_rs;
    logic [7:0]       send_data;
    logic             busy, shown;
    logic             acked;
    logic             restart;
    logic             tmr_clr, tmr_en, tmr_done;
    logic [TW-1:0]    tmr_term;

    function automatic logic [7:0] char_at(input logic [N*8-1:0] text,
                                           input logic [LW-1:0]  ln,
                                           input logic [CW-1:0]  cl);
        int c;
        c = int'(ln) * LINE_LEN + int'(cl);
        return text[(N-1-c)*8 +: 8];
    endfunction

    function automatic logic [7:0] line_cmd(input logic [LW-1:0] ln);
        return CMD_SET_DDRAM | 8'(8'(ln) * LINE_STRIDE);
    endfunction

    assign acked = req && iLCD_ACK;

    delay_timer #(.W(TW)) u_timer (
        .clk   (iCLK),
        .rst_n (iRST_N),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .term  (tmr_term),
        .done  (tmr_done)
    );

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state    <= PWR_WAIT;
            init_idx <= '0;
            line     <= '0;
            col      <= '0;
            shadow   <= '0;
            cmp      <= '0;
            pending  <= 1'b0;
            req      <= 1'b0;
            rs       <= RS_CMD;
            data     <= '0;
        end else begin
            state    <= state_nx;
            init_idx <= init_idx_nx;
            line     <= line_nx;
            col      <= col_nx;
            shadow   <= shadow_nx;
            cmp      <= cmp_nx;
            pending  <= pending_nx;
            req      <= req_nx;
            // RS/DATA only load as REQ rises, so they hold for the whole request.
            if (req_nx && !req) begin
                rs   <= send_rs;
                data <= send_data;
            end
        end
    end

    always_comb begin
        state_nx    = state;
        init_idx_nx = init_idx;
        line_nx     = line;
        col_nx      = col;
        shadow_nx   = shadow;
        cmp_nx      = cmp;
        pending_nx  = pending;
        restart     = 1'b0;
        tmr_en      = 1'b0;
        tmr_term    = PWR_TERM;

        case (state)
            PWR_WAIT: begin
                tmr_en = 1'b1;
                if (iREFRESH) pending_nx = 1'b1;
                if (tmr_done) state_nx = INIT;
            end
            INIT: begin
                if (iREFRESH) pending_nx = 1'b1;
                if (acked) begin
                    if (init_idx == INIT_CLR_IDX) begin
                        init_idx_nx = INIT_LAST_IDX;
                        state_nx    = CLR_WAIT;
                    end else if (init_idx == INIT_LAST_IDX) begin
                        shadow_nx  = iDATA;
                        pending_nx = 1'b0;
                        line_nx    = '0;
                        state_nx   = ADDR;
                    end else begin
                        init_idx_nx = init_idx + 2'd1;
                    end
                end
            end
            CLR_WAIT: begin
                tmr_en   = 1'b1;
                tmr_term = CLR_TERM;
                if (iREFRESH) pending_nx = 1'b1;
                if (tmr_done) state_nx = INIT;
            end
            ADDR: begin
                if (iREFRESH) pending_nx = 1'b1;
                if (acked) begin
                    col_nx   = '0;
                    state_nx = CHAR;
                end
            end
            CHAR: begin
                if (iREFRESH) pending_nx = 1'b1;
                if (acked) begin
                    if (col == LAST_COL) begin
                        col_nx = '0;
                        if (line == LAST_LINE) begin
                            state_nx = SHOWN;
                        end else begin
                            line_nx  = line + 1'b1;
                            state_nx = ADDR;
                        end
                    end else begin
                        col_nx = col + 1'b1;
                    end
                end
            end
            SHOWN: begin
                if (pending || iREFRESH) begin
                    shadow_nx  = iDATA;
                    pending_nx = 1'b0;
                    line_nx    = '0;
                    state_nx   = ADDR;
                end else if (iDATA != shadow) begin
                    cmp_nx   = iDATA;
                    state_nx = SETTLE;
                end
            end
            SETTLE: begin
                tmr_en   = 1'b1;
                tmr_term = SETTLE_TERM;
                if (iREFRESH) begin
                    shadow_nx  = iDATA;
                    pending_nx = 1'b0;
                    line_nx    = '0;
                    state_nx   = ADDR;
                end else if (iDATA == shadow) begin
                    state_nx = SHOWN;
                end else if (iDATA != cmp) begin
                    // Text still moving: track it and restart the settle window.
                    cmp_nx  = iDATA;
                    restart = 1'b1;
                end else if (tmr_done) begin
                    shadow_nx = cmp;
                    line_nx   = '0;
                    state_nx  = ADDR;
                end
            end
            default: state_nx = PWR_WAIT;
        endcase

        // Every wait starts from zero on state entry.
        tmr_clr = restart || (state_nx != state);
        // REQ falls after ACK and may rise again one cycle later; a new
        // request is raised as soon as the next state has a byte to send.
        req_nx  = req ? !iLCD_ACK : is_send_state(state_nx);
    end

    always_comb begin
        busy      = 1'b1;
        shown     = 1'b0;
        send_rs   = RS_CMD;
        send_data = 8'h00;
        if (state == SHOWN || state == SETTLE) begin
            busy  = 1'b0;
            shown = 1'b1;
        end
        // Byte to present when REQ rises next cycle (looked up from the next state).
        case (state_nx)
            INIT: send_data = init_cmd(init_idx);
            ADDR: send_data = line_cmd(line_nx);
            CHAR: begin
                send_rs   = RS_CHAR;
                send_data = char_at(shadow, line, col);
            end
            default: ;
        endcase
    end

    assign oLCD_REQ  = req;
    assign oLCD_RS   = rs;
    assign oLCD_DATA = data;
    assign oBUSY     = busy;
    assign oSHOWN    = shown;

endmodule

// File: tb/tb_lcd_refresh_sched.sv
// Self-checking bench for lcd_refresh_sched using small wait constants.
// Expected writer bytes are queued when stimulus is issued; a monitor pops
// and compares them as the DUT raises requests.
module tb_lcd_refresh_sched;

    localparam int PWR = 16;
    localparam int CLR = 8;
    localparam int SET = 4;
    localparam int NL  = 2;
    localparam int LL  = 4;
    localparam int N   = NL * LL;

    logic           clk;
    logic           rst_n;
    logic [N*8-1:0] data_bus;
    logic           refresh;
    logic           req;
    logic           rs;
    logic [7:0]     data;
    logic           ack;
    logic           busy;
    logic           shown;

    int total = 0;
    int bad   = 0;
    int byte_cnt = 0;
    logic slow_arm = 1'b0;

    logic [8:0] exp_q[$];
    logic [7:0] txt[N];

    lcd_refresh_sched #(
        .N_LINES(NL), .LINE_LEN(LL), .PWR_CYC(PWR), .CLR_CYC(CLR), .SETTLE_CYC(SET)
    ) dut (
        .iCLK(clk), .iRST_N(rst_n), .iDATA(data_bus), .iREFRESH(refresh),
        .oLCD_REQ(req), .oLCD_RS(rs), .oLCD_DATA(data), .iLCD_ACK(ack),
        .oBUSY(busy), .oSHOWN(shown)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_range(input string nm, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d at %0t", nm, act, lo, hi, $time);
        end
    endtask

    // Reference model: what one write pass of the current text looks like.
    task automatic push_pass();
        for (int l = 0; l < NL; l++) begin
            exp_q.push_back({1'b0, 8'h80 + 8'(l * 64)});
            for (int c = 0; c < LL; c++) exp_q.push_back({1'b1, txt[l*LL + c]});
        end
    endtask

    task automatic push_init();
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b0, 8'h06});
    endtask

    task automatic apply_text();
        for (int c = 0; c < N; c++) data_bus[(N-1-c)*8 +: 8] = txt[c];
    endtask

    task automatic set_text(input string s);
        for (int c = 0; c < N; c++) txt[c] = s[c];
        apply_text();
    endtask

    task automatic random_text();
        logic [7:0] old[N];
        bit same;
        old = txt;
        same = 1'b1;
        for (int c = 0; c < N; c++) begin
            txt[c] = 8'($urandom_range(32, 126));
            if (txt[c] != old[c]) same = 1'b0;
        end
        if (same) txt[0] = txt[0] ^ 8'h01;
        apply_text();
    endtask

    task automatic edges_to_req(output int k);
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (!req && k < 300);
    endtask

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (!(exp_q.size() == 0 && shown && !req) && k < 3000);
        chk({nm, " idle reached"}, int'(k < 3000), 1);
        chk({nm, " busy low when shown"}, int'(busy), 0);
    endtask

    task automatic pulse_refresh();
        @(negedge clk);
        refresh = 1'b1;
        @(negedge clk);
        refresh = 1'b0;
    endtask

    // Writer model: ACK two cycles into a request, ten on the armed slow char.
    initial begin
        int hold;
        int dly;
        int pass_char;
        ack = 1'b0;
        hold = 0;
        dly = 2;
        pass_char = 0;
        forever begin
            @(negedge clk);
            if (ack) begin
                ack = 1'b0;
                hold = 0;
            end else if (rst_n && req) begin
                hold++;
                if (hold == 1) begin
                    if (!rs && data == 8'h80) pass_char = 0;
                    if (rs) pass_char++;
                    dly = 2;
                    if (slow_arm && rs && pass_char == 3) begin
                        dly = 10;
                        slow_arm = 1'b0;
                    end
                end
                if (hold >= dly) ack = 1'b1;
            end else begin
                hold = 0;
            end
        end
    end

    // Monitor: compares each new request against the scoreboard and checks
    // the handshake shape (hold stability, low gap between bytes).
    initial begin
        int gap;
        int unstable;
        bit in_b;
        bit prev_v;
        logic [8:0] held;
        logic [8:0] prevb;
        logic [8:0] e;
        gap = 0; unstable = 0; in_b = 0; prev_v = 0; held = '0; prevb = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_b = 0; prev_v = 0; gap = 0;
            end else if (req) begin
                if (!in_b) begin
                    in_b = 1;
                    held = {rs, data};
                    unstable = 0;
                    if (exp_q.size() == 0) begin
                        chk("spurious byte", int'(held), -1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("byte", int'(held), int'(e));
                    end
                    if (prev_v) begin
                        if (prevb == 9'h001) chk("clear wait gap", gap, CLR);
                        else chk_range("byte gap", gap, 1, 1000);
                    end
                    byte_cnt++;
                end else if ({rs, data} != held) begin
                    unstable++;
                end
            end else begin
                if (in_b) begin
                    chk("request hold stable", unstable, 0);
                    prevb = held;
                    prev_v = 1;
                    in_b = 0;
                    gap = 0;
                end
                gap++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, queue=%0d", exp_q.size());
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        int k;
        int bc0;
        logic [7:0] save;

        rst_n = 1'b0;
        refresh = 1'b0;
        data_bus = '0;
        set_text("ABCDEFGH");
        repeat (3) @(negedge clk);
        chk("reset req", int'(req), 0);
        chk("reset rs", int'(rs), 0);
        chk("reset data", int'(data), 0);
        chk("reset busy", int'(busy), 1);
        chk("reset shown", int'(shown), 0);

        // Power-up, init list and first pass.
        push_init();
        push_pass();
        rst_n = 1'b1;
        edges_to_req(k);
        chk("power-up wait edges", k, PWR);
        wait_idle("first pass");

        // Single change held stable.
        @(negedge clk);
        txt[7] = "X";
        apply_text();
        push_pass();
        edges_to_req(k);
        chk_range("settle latency", k, SET, SET + 2);
        wait_idle("change pass");

        // Bouncing text: nothing until it settles on the final value.
        bc0 = byte_cnt;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            txt[7] = (i % 2 == 1) ? "Y" : "Z";
            apply_text();
            if (i < 6) repeat (2) @(negedge clk);
        end
        chk("no pass while toggling", byte_cnt - bc0, 0);
        push_pass();
        edges_to_req(k);
        chk_range("settle after toggling", k, SET, SET + 2);
        wait_idle("toggle pass");

        // Change reverted before the window expires.
        bc0 = byte_cnt;
        @(negedge clk);
        save = txt[0];
        txt[0] = save ^ 8'h20;
        apply_text();
        repeat (2) @(negedge clk);
        txt[0] = save;
        apply_text();
        repeat (20) @(negedge clk);
        chk("revert gives no pass", byte_cnt - bc0, 0);
        chk("revert stays shown", int'(shown), 1);

        // Random texts and immediate refreshes.
        for (int it = 0; it < 4; it++) begin
            @(negedge clk);
            random_text();
            push_pass();
            wait_idle("random pass");
            push_pass();
            @(negedge clk);
            refresh = 1'b1;
            edges_to_req(k);
            refresh = 1'b0;
            chk_range("refresh latency", k, 1, 2);
            wait_idle("refresh pass");
        end

        // Refresh and text change during CHAR, with a slow ACK on char 3.
        slow_arm = 1'b1;
        push_pass();
        pulse_refresh();
        k = 0;
        do begin @(posedge clk); #1; k++; end while (!(req && rs) && k < 300);
        chk("reached char state", int'(req && rs), 1);
        @(negedge clk);
        random_text();
        refresh = 1'b1;
        push_pass();
        @(negedge clk);
        refresh = 1'b0;
        k = 0;
        do begin @(posedge clk); #1; k++; end while (!shown && k < 500);
        chk("first pass finished", int'(shown), 1);
        @(posedge clk); #1;
        chk("pending pass starts next cycle", int'(req), 1);
        chk("shown drops on new pass", int'(shown), 0);
        wait_idle("pending pass");

        // Reset in the middle of a pass.
        push_pass();
        pulse_refresh();
        k = 0;
        do begin @(posedge clk); #1; k++; end while (!(req && rs) && k < 300);
        chk("reached char before reset", int'(req && rs), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid-pass reset req", int'(req), 0);
        chk("mid-pass reset busy", int'(busy), 1);
        chk("mid-pass reset shown", int'(shown), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        push_init();
        push_pass();
        rst_n = 1'b1;
        edges_to_req(k);
        chk("power-up wait after reset", k, PWR);
        wait_idle("post-reset pass");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
